aes_key_schedule_ctrl: RTL

//  Sequential AES-128 key-schedule controller. Latches a 128-bit cipher key and streams

---
 rtl/aes_key_schedule_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule controller: latches a cipher key and streams round keys 0..NUM_ROUNDS
// over valid/ready, using an external shared S-box. Define AES_KEY_STORE_EN to add a rdIdx/rdKey key store.
module aes_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipherKey,
  output logic         ready,
  input  logic         abort,
  output logic [127:0] roundKey,
  output logic [3:0]   roundIdx,
  output logic         rkValid,
  input  logic         rkReady,
  output logic         done,
  output logic [31:0]  sboxIn,
  input  logic [31:0]  sboxOut
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rdIdx,
  output logic [127:0] rdKey
`endif
);

  localparam logic [3:0] LAST_IDX  = 4'(NUM_ROUNDS);
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           hs;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // sub is SubWord(RotWord(w3)) returned by the shared S-box for the current key.
  function automatic logic [127:0] next_key(input logic [127:0] k,
                                            input logic [31:0]  sub,
                                            input logic [7:0]   rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub ^ {rc, 24'h0};
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // abort outranks the handshake, so a key offered in the abort cycle is not consumed.
  assign hs = (state_q == STREAM) && rkReady && !abort;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          key_d   = cipherKey;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
        end else if (rkReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            key_d  = next_key(key_q, sboxOut, rcon_q);
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      FINISH: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
        end else if (start) begin
          state_d = STREAM;
          key_d   = cipherKey;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
        rcon_d  = RCON_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign ready    = (state_q != STREAM);
  assign rkValid  = (state_q == STREAM);
  assign done     = (state_q == FINISH);
  assign roundKey = key_q;
  assign roundIdx = idx_q;
  assign sboxIn   = rot_word(key_q[31:0]);

`ifdef AES_KEY_STORE_EN
  // Every emitted key is kept so the decrypt path can replay them in reverse order.
  logic [127:0] store_q [NUM_ROUNDS+1];
  logic [127:0] store_d [NUM_ROUNDS+1];

  always_comb begin
    store_d = store_q;
    if (hs) begin
      store_d[idx_q] = key_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      store_q <= store_d;
    end
  end

  assign rdKey = (rdIdx <= LAST_IDX) ? store_q[rdIdx] : '0;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule
